// File: rtl/priority_scanner.sv
// Sequential priority scanner: accepts a request vector and emits each set bit as one beat,
// LSB-first or MSB-first, with one-hot/index, popcount, last and zero flags.
module priority_scanner #(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned IDXW = $clog2(WIDTH),
  localparam int unsigned CNTW = $clog2(WIDTH + 1)
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              data_val_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic              data_dir_i,
  output logic              data_ready_o,
  output logic [WIDTH-1:0]  data_onehot_o,
  output logic [IDXW-1:0]   data_idx_o,
  output logic [CNTW-1:0]   data_cnt_o,
  output logic              data_last_o,
  output logic              data_zero_o,
  output logic              data_val_o,
  input  logic              data_ready_i
);

  typedef enum logic {StIdle, StScan} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] residual_q, residual_d;
  logic             dir_q, dir_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             zero_q, zero_d;
  // Holds ready low until the first edge after reset release.
  logic             init_q;

  logic [WIDTH-1:0] lsb_bit, msb_bit, sel_bit;
  logic [IDXW-1:0]  sel_idx;
  logic             single;
  logic [CNTW-1:0]  popcnt;
  logic             scan, accept, beat_done;

  // Bit selection, decoded from registered state only.
  always_comb begin
    lsb_bit = residual_q & (~residual_q + WIDTH'(1));
    msb_bit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (residual_q[i]) begin
        msb_bit    = '0;
        msb_bit[i] = 1'b1;
      end
    end
    sel_bit = dir_q ? msb_bit : lsb_bit;
    sel_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel_bit[i]) begin
        sel_idx = sel_idx | IDXW'(i);
      end
    end
    // Zero or one bit left; an all-zero residual is its own last beat.
    single = (residual_q & (residual_q - WIDTH'(1))) == '0;
  end

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      popcnt = popcnt + CNTW'(data_i[i]);
    end
  end

  assign scan      = (state_q == StScan);
  assign accept    = (state_q == StIdle) && init_q && data_val_i;
  assign beat_done = scan && data_ready_i;

  always_comb begin
    state_d    = state_q;
    residual_d = residual_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    zero_d     = zero_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          residual_d = data_i;
          dir_d      = data_dir_i;
          cnt_d      = popcnt;
          zero_d     = (data_i == '0);
          state_d    = StScan;
        end
      end
      StScan: begin
        if (beat_done) begin
          residual_d = residual_q & ~sel_bit;
          if (single) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= StIdle;
      residual_q <= '0;
      dir_q      <= 1'b0;
      cnt_q      <= '0;
      zero_q     <= 1'b0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      residual_q <= residual_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      zero_q     <= zero_d;
      init_q     <= 1'b1;
    end
  end

  always_comb begin
    data_ready_o  = init_q && (state_q == StIdle);
    data_val_o    = scan;
    data_onehot_o = scan ? sel_bit : '0;
    data_idx_o    = scan ? sel_idx : '0;
    data_cnt_o    = scan ? cnt_q : '0;
    data_last_o   = scan && single;
    data_zero_o   = scan && zero_q;
  end

endmodule

// File: tb/tb_priority_scanner.sv
// Randomized self-checking bench for priority_scanner (WIDTH=5) against a queue-based model.
module tb_priority_scanner;

  localparam int unsigned W = 5;

  logic         clk = 1'b0;
  logic         arst;
  logic         val_i;
  logic [W-1:0] data;
  logic         dir;
  logic         ready_o;
  logic [W-1:0] onehot;
  logic [2:0]   idx;
  logic [2:0]   cnt;
  logic         last;
  logic         zero;
  logic         val_o;
  logic         ready_i;

  int n_total = 0;
  int n_bad   = 0;

  priority_scanner #(.WIDTH(W)) dut (
    .clk_i        (clk),
    .arst_i       (arst),
    .data_val_i   (val_i),
    .data_i       (data),
    .data_dir_i   (dir),
    .data_ready_o (ready_o),
    .data_onehot_o(onehot),
    .data_idx_o   (idx),
    .data_cnt_o   (cnt),
    .data_last_o  (last),
    .data_zero_o  (zero),
    .data_val_o   (val_o),
    .data_ready_i (ready_i)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"},  int'(ready_o), 0);
    check_eq({tag, "_val"},    int'(val_o), 0);
    check_eq({tag, "_onehot"}, int'(onehot), 0);
    check_eq({tag, "_idx"},    int'(idx), 0);
    check_eq({tag, "_cnt"},    int'(cnt), 0);
    check_eq({tag, "_last"},   int'(last), 0);
    check_eq({tag, "_zero"},   int'(zero), 0);
  endtask

  // Enters and leaves at a falling edge. mode: 0 ready high, 1 pattern 1,0,0, 2 random.
  // Beats with index >= stop_after are not consumed (caller takes over, e.g. for reset).
  task automatic run_vec(input logic [W-1:0] v, input logic d, input int mode,
                         input logic hold_val, input int stop_after);
    int exp_q[$];
    int guard;
    int k;
    int c;
    logic rdy;
    guard = 0;
    while (ready_o !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (ready_o !== 1'b1) begin
      check_eq("accept_timeout", int'(ready_o), 1);
      return;
    end
    val_i = 1'b1;
    data  = v;
    dir   = d;
    if (d == 1'b0) begin
      for (int i = 0; i < W; i++) if (((v >> i) & 1) == 1) exp_q.push_back(i);
    end else begin
      for (int i = W - 1; i >= 0; i--) if (((v >> i) & 1) == 1) exp_q.push_back(i);
    end
    if (exp_q.size() == 0) exp_q.push_back(-1);
    k = 0;
    c = 0;
    guard = 0;
    while (k < exp_q.size() && guard < 200) begin
      @(negedge clk);
      guard++;
      val_i = hold_val;
      data  = W'($urandom);
      dir   = 1'($urandom);
      if (k >= stop_after) return;
      check_eq("beat_val",   int'(val_o), 1);
      check_eq("beat_ready", int'(ready_o), 0);
      check_eq("beat_onehot", int'(onehot), (exp_q[k] < 0) ? 0 : (1 << exp_q[k]));
      check_eq("beat_idx",   int'(idx), (exp_q[k] < 0) ? 0 : exp_q[k]);
      check_eq("beat_cnt",   int'(cnt), (exp_q[k] < 0) ? 0 : exp_q.size());
      check_eq("beat_last",  int'(last), int'(k == exp_q.size() - 1));
      check_eq("beat_zero",  int'(zero), int'(v == 0));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      c++;
      ready_i = rdy;
      if (rdy) k++;
    end
    if (k < exp_q.size()) begin
      check_eq("beat_timeout", k, exp_q.size());
      return;
    end
    @(negedge clk);
    ready_i = 1'($urandom_range(0, 1));
    check_eq("post_val",   int'(val_o), 0);
    check_eq("post_ready", int'(ready_o), 1);
  endtask

  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      val_i = 1'b0;
      data  = W'($urandom);
      dir   = 1'($urandom);
      @(negedge clk);
      check_eq("idle_val",   int'(val_o), 0);
      check_eq("idle_ready", int'(ready_o), 1);
    end
  endtask

  initial begin
    arst    = 1'b1;
    val_i   = 1'b0;
    data    = '0;
    dir     = 1'b0;
    ready_i = 1'b0;
    #12;
    check_all_zero("rst");
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", int'(ready_o), 1);
    check_eq("rst_val",   int'(val_o), 0);

    run_vec(5'b10110, 1'b0, 0, 1'b0, 99);
    run_vec(5'b10110, 1'b1, 0, 1'b0, 99);
    run_vec(5'b00000, 1'b0, 0, 1'b0, 99);
    run_vec(5'b11111, 1'b0, 1, 1'b0, 99);
    idle_noise(3);
    // Back-to-back with valid held high through the scan.
    run_vec(5'b00001, 1'b0, 0, 1'b1, 99);
    run_vec(5'b10000, 1'b1, 0, 1'b0, 99);
    idle_noise(2);

    // Reset in the middle of a scan, after the first beat was taken.
    run_vec(5'b01110, 1'b0, 0, 1'b0, 1);
    val_i   = 1'b0;
    ready_i = 1'b1;
    arst    = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    check_all_zero("mid_rst_held");
    arst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_ready", int'(ready_o), 1);
    check_eq("mid_rst_val",   int'(val_o), 0);
    run_vec(5'b00100, 1'b0, 0, 1'b0, 99);

    for (int t = 0; t < 60; t++) begin
      run_vec(W'($urandom), 1'($urandom), 2, 1'($urandom), 99);
      if ($urandom_range(0, 3) == 0) idle_noise(int'($urandom_range(1, 3)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/priority_scanner.md
# priority_scanner

Sequential, parametrised successor to the single-shot priority encoder. Accepts a WIDTH-bit request vector through a valid/ready handshake, then emits every set bit, one per output beat, in a per-vector selectable order: LSB-first or MSB-first. Each beat carries the bit as both one-hot and binary index, plus the vector's population count and a last flag. Sits between request-collection logic and a downstream consumer that services one request per cycle with backpressure.

## Interface
- WIDTH, 16, request vector width; legal range ≥ 2
- IDXW, $clog2(WIDTH), index width (derived localparam)
- CNTW, $clog2(WIDTH+1), popcount width (derived localparam)
- clk_i  in  1  clock; all state changes on rising edge
- arst_i  in  1  asynchronous active-high reset
- data_val_i  in  1  input vector valid
- data_i  in  WIDTH  request vector
- data_dir_i  in  1  scan order, sampled with data_i: 0 = LSB-first, 1 = MSB-first
- data_ready_o  out  1  block can accept a vector
- data_onehot_o  out  WIDTH  current set bit, one-hot
- data_idx_o  out  IDXW  binary index of current set bit
- data_cnt_o  out  CNTW  popcount of the accepted vector, constant for all its beats
- data_last_o  out  1  current beat is the final one of the vector
- data_zero_o  out  1  accepted vector was all-zero
- data_val_o  out  1  output beat valid
- data_ready_i  in  1  downstream accepts the beat

## Operation
- FSM with two states: IDLE and SCAN. Reset state is IDLE.
- IDLE:
  - data_ready_o=1, data_val_o=0.
  - On data_val_i && data_ready_o, register the vector into the residual register, latch dir, compute and register popcount, then go to SCAN.
  - data_i and data_dir_i are ignored when data_val_i=0.
- SCAN:
  - data_ready_o=0, data_val_o=1.
  - Current beat is the lowest set bit of the residual for dir=0, or the highest set bit for dir=1.
  - data_idx_o is the binary encoding of data_onehot_o.
  - data_last_o=1 when the residual has exactly one set bit.
- Beat handshake (data_val_o && data_ready_i):
  - Clear the emitted bit from the residual.
  - If data_last_o=1, return to IDLE.
- All-zero vector:
  - Produces exactly one beat: data_zero_o=1, data_last_o=1, data_onehot_o=0, data_idx_o=0, data_cnt_o=0.
  - Returns to IDLE on handshake.
- Backpressure: while data_val_o=1 && data_ready_i=0, all data_* outputs stay stable.
- data_zero_o=0 for every beat of a non-zero vector.
- Full vector (all ones): data_cnt_o=WIDTH, which CNTW holds without overflow.

## Timing
- Reset values: data_ready_o=1 once arst_i is sampled low.
- While arst_i is high, all other outputs are 0 and data_ready_o=0.
- Reset mid-SCAN: state, residual and outputs clear immediately (asynchronously); the partial transaction is discarded and no last beat is produced.
- Latency: vector accepted at edge N, so the first beat is valid after edge N (cycle N+1).
- Throughput:
  - Non-zero vector: max(popcount,1) beats + 1 accept cycle per vector with data_ready_i tied high.
  - data_ready_o is not asserted in the cycle of the last-beat handshake; a new vector is accepted one cycle later.
- Outputs are registered or decoded from registered state only; there is no combinational path from data_i or data_ready_i to any output.

## Test plan
- WIDTH=5, data_i=5'b10110, dir=0, ready_i=1 -> 3 consecutive beats:
  - idx 1, 2, 4; onehot 00010, 00100, 10000
  - cnt=3 on every beat; last only on beat 3
  - ready_o high again the cycle after beat 3
- Same vector, dir=1 -> beats idx 4, 2, 1; cnt=3; last on idx 1.
- data_i=5'b00000 -> single beat with zero=1, last=1, onehot=0, idx=0, cnt=0.
- data_i=5'b11111, dir=0, ready_i toggling 1,0,0,1,... -> five beats idx 0..4, each held stable while ready_i=0; cnt=5; no beat lost or repeated.
- Back-to-back: 5'b00001 then 5'b10000 (dir=1), with data_val_i held high:
  - beat idx 0 (last)
  - 1 idle cycle with ready_o=1
  - beat idx 4 (last)
  - data_val_i=0 vectors between them are ignored
- arst_i pulsed mid-scan of 5'b01110 after the first beat -> outputs 0 immediately. After release, ready_o=1 and the next vector 5'b00100 yields a single beat idx 2, cnt=1.
